// File: rtl/branch_compare_unit.sv
// branch_compare_unit: multi-cycle RV32I branch condition resolver, MSB chunk first,
// stopping at the first differing chunk.
module branch_compare_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] RD1,
    input  logic [WIDTH-1:0] RD2,
    output logic             busy,
    output logic             done,
    output logic             BrRes,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_cnt
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] a, b, flip;
    logic [CHUNK-1:0] a_k, b_k;
    logic [KW-1:0] k;
    logic use_lt, inv, eq_k, last, res, accept, bad, resolve;
    // Flipping the sign bit of both operands turns a signed compare into an unsigned one.
    assign flip = (funct3[2] && !funct3[1]) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
    // Operands shift left each SCAN cycle so the current chunk is always the top one.
    assign a_k = a[WIDTH-1 -: CHUNK];
    assign b_k = b[WIDTH-1 -: CHUNK];
    assign eq_k = a_k == b_k;
    assign last = k == KW'(NCHUNK - 1);
    assign res = (use_lt ? a_k < b_k : eq_k) ^ inv;
    assign busy = state == SCAN;
    always_comb begin
        state_n = state;
        accept = 1'b0;
        bad = 1'b0;
        resolve = 1'b0;
        if (state == IDLE) begin
            bad = start && !flush && funct3[2:1] == 2'b01;
            accept = start && !flush && funct3[2:1] != 2'b01;
            state_n = accept ? SCAN : IDLE;
        end else begin
            resolve = !flush && (!eq_k || last);
            state_n = (flush || resolve) ? IDLE : SCAN;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0;
            b <= '0;
            k <= '0;
            use_lt <= 1'b0;
            inv <= 1'b0;
            done <= 1'b0;
            BrRes <= 1'b0;
            illegal <= 1'b0;
            taken_cnt <= '0;
        end else begin
            done <= resolve || bad;
            if (accept) begin
                a <= RD1 ^ flip;
                b <= RD2 ^ flip;
                k <= '0;
                use_lt <= funct3[2];
                inv <= funct3[0];
            end else if (state == SCAN) begin
                a <= a << CHUNK;
                b <= b << CHUNK;
                k <= k + 1'b1;
            end
            if (bad) begin
                illegal <= 1'b1;
                BrRes <= 1'b0;
            end
            if (resolve) begin
                illegal <= 1'b0;
                BrRes <= res;
                if (res && !(&taken_cnt)) taken_cnt <= taken_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_compare_unit.sv
// tb_branch_compare_unit: directed and random checks of branch_compare_unit against
// a latency/result model computed from whole-operand arithmetic.
module tb_branch_compare_unit;
    localparam int W = 32;
    localparam int C = 8;
    localparam int N = W / C;
    logic clk = 0, rst = 0, start = 0, flush = 0;
    logic [2:0] funct3 = 0;
    logic [W-1:0] rd1 = 0, rd2 = 0;
    logic busy, done, br_res, illegal;
    logic [15:0] taken_cnt;
    logic busy2, done2, br_res2, illegal2;
    logic [1:0] taken_cnt2;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    branch_compare_unit #(.WIDTH(W), .CHUNK(C), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
        .RD1(rd1), .RD2(rd2), .busy(busy), .done(done), .BrRes(br_res),
        .illegal(illegal), .taken_cnt(taken_cnt));
    branch_compare_unit #(.WIDTH(W), .CHUNK(C), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
        .RD1(rd1), .RD2(rd2), .busy(busy2), .done(done2), .BrRes(br_res2),
        .illegal(illegal2), .taken_cnt(taken_cnt2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_res(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        case (f)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            default: return a >= b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a ^ b;
        for (int j = 0; j < N; j++)
            if (d[W-1-j*C -: C] != 0) return j + 1;
        return N;
    endfunction

    // Model: a compare is a countdown of its latency, then it publishes a precomputed result.
    logic m_busy, m_done, m_res, m_ill, p_res;
    int m_rem;
    logic [15:0] m_cnt;
    logic [1:0] m_cnt2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_res <= 0; m_ill <= 0; p_res <= 0;
            m_rem <= 0; m_cnt <= 0; m_cnt2 <= 0;
        end else begin
            m_done <= 0;
            if (m_busy) begin
                if (flush) m_busy <= 0;
                else if (m_rem == 1) begin
                    m_busy <= 0; m_done <= 1; m_res <= p_res; m_ill <= 0;
                    if (p_res) begin
                        if (m_cnt != 16'hffff) m_cnt <= m_cnt + 1;
                        if (m_cnt2 != 2'd3) m_cnt2 <= m_cnt2 + 1;
                    end
                end else m_rem <= m_rem - 1;
            end else if (start && !flush) begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    m_done <= 1; m_ill <= 1; m_res <= 0;
                end else begin
                    m_busy <= 1;
                    m_rem <= ref_lat(rd1, rd2);
                    p_res <= ref_res(funct3, rd1, rd2);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("BrRes", br_res, m_res);
        chk("illegal", illegal, m_ill);
        chk("taken_cnt", taken_cnt, m_cnt);
        chk("taken_cnt2", taken_cnt2, m_cnt2);
    end

    task automatic op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b, output int n);
        @(negedge clk);
        start = 1; funct3 = f; rd1 = a; rd2 = b;
        @(negedge clk);
        start = 0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, nd, t;
        logic r;
        logic [31:0] exp2 [5];
        exp2 = '{1, 2, 3, 3, 3};
        #2 rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_busy", busy, 0);
        chk("rst_cnt", taken_cnt, 0);
        chk("rst_brres", br_res, 0);
        op(3'b000, 32'h1234_5678, 32'h1234_5678, n);
        chk("beq_lat", n, 4); chk("beq_res", br_res, 1); chk("beq_cnt", taken_cnt, 1);
        op(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, n);
        chk("blt_lat", n, 1); chk("blt_res", br_res, 1); chk("blt_cnt", taken_cnt, 2);
        op(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, n);
        chk("bltu_lat", n, 1); chk("bltu_res", br_res, 0); chk("bltu_cnt", taken_cnt, 2);
        op(3'b001, 32'h0, 32'h1, n);
        chk("bne_lat", n, 4); chk("bne_res", br_res, 1); chk("bne_cnt", taken_cnt, 3);
        op(3'b101, 32'h8000_0000, 32'h8000_0000, n);
        chk("bge_lat", n, 4); chk("bge_res", br_res, 1); chk("bge_cnt", taken_cnt, 4);
        op(3'b010, 32'h0, 32'h0, n);
        chk("ill_lat", n, 0); chk("ill_flag", illegal, 1); chk("ill_res", br_res, 0);
        chk("ill_cnt", taken_cnt, 4);
        op(3'b000, 32'h5, 32'h6, n);
        chk("beq_ne_lat", n, 4); chk("beq_ne_res", br_res, 0); chk("beq_ne_ill", illegal, 0);
        op(3'b001, 32'h1, 32'h0, n);
        chk("bne_last_res", br_res, 1); chk("bne_last_cnt", taken_cnt, 5);
        // Flush in the second SCAN cycle.
        @(negedge clk); start = 1; funct3 = 3'b000; rd1 = 32'h7; rd2 = 32'h7;
        @(negedge clk); start = 0;
        @(negedge clk); flush = 1;
        @(negedge clk); flush = 0;
        chk("flush_busy", busy, 0); chk("flush_done", done, 0);
        chk("flush_res", br_res, 1); chk("flush_cnt", taken_cnt, 5);
        nd = 0;
        repeat (5) begin @(negedge clk); if (done) nd++; end
        chk("flush_no_done", nd, 0);
        // A start during SCAN must not be taken.
        @(negedge clk); start = 1; funct3 = 3'b000; rd1 = 32'h9; rd2 = 32'h9;
        @(negedge clk); start = 0;
        @(negedge clk); start = 1; funct3 = 3'b001;
        @(negedge clk); start = 0;
        nd = 0; r = 0;
        repeat (8) begin @(negedge clk); if (done) begin nd++; r = br_res; end end
        chk("scan_start_dones", nd, 1); chk("scan_start_res", r, 1);
        chk("scan_start_cnt", taken_cnt, 6);
        // Asynchronous reset in the middle of SCAN.
        @(negedge clk); start = 1; funct3 = 3'b000; rd1 = 0; rd2 = 0;
        @(negedge clk); start = 0;
        #2 rst = 1;
        #1;
        chk("arst_busy", busy, 0); chk("arst_done", done, 0); chk("arst_res", br_res, 0);
        chk("arst_ill", illegal, 0); chk("arst_cnt", taken_cnt, 0);
        @(negedge clk); rst = 0;
        // Back-to-back taken compares saturate the narrow counter.
        @(negedge clk); start = 1; funct3 = 3'b001; rd1 = 32'h0100_0000; rd2 = 0;
        nd = 0; t = 0;
        while (nd < 5 && t < 40) begin
            @(negedge clk);
            t++;
            if (done2) begin
                chk("cnt2_seq", taken_cnt2, exp2[nd]);
                nd++;
            end
        end
        start = 0;
        chk("cnt2_dones", nd, 5);
        repeat (3000) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            funct3 = 3'($urandom);
            rd1 = $urandom;
            case ($urandom_range(0, 3))
                0: rd2 = rd1;
                1: rd2 = rd1 ^ (32'h1 << $urandom_range(0, 31));
                2: rd2 = rd1 ^ 32'h8000_0000;
                default: rd2 = $urandom;
            endcase
            flush = $urandom_range(0, 15) == 0;
            rst = $urandom_range(0, 499) == 0;
        end
        @(negedge clk); start = 0; flush = 0; rst = 0;
        repeat (6) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
